dot_scoreboard: RTL and testbench

Read-side consumer of the dot grid's 308-bit `show` vector; bit set = dot gone (eaten, or never present: walls, ghost-box slots). Scans the vector one bit per clock, compares each bit against a snapshot from the previous pass, and turns 0→1 transitions into score increments and eat pulses. Once per pass it publishes the count of dots still on the board and flags level clear. Sits between the dot grid and the score/HUD and sound logic, on the main `Clk` domain.

---
 rtl/dot_scoreboard.sv | 137 +++++++++++++
 tb/tb_dot_scoreboard.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dot_scoreboard.sv
// dot_scoreboard
//   Scans the dot grid's `show` vector one bit per clock, compares each bit
//   with the value seen on the previous pass, and turns newly-absent dots
//   (0 -> 1) into score increments and eat pulses. Once per pass it
//   publishes the number of dots still present and flags level clear.
//
// Ports
//   Clk          system clock (only clock)
//   Reset        synchronous, active-high reset
//   show         dot grid state, bit i = 1 means dot i is absent
//   score_clr    synchronous clear of score only
//   score        accumulated score, saturating at all-ones
//   dots_left    count of present dots from the last completed pass
//   eat_pulse    one-cycle pulse per detected eaten dot
//   pass_done    one-cycle pulse when a pass result is published
//   level_clear  one-cycle pulse when dots_left becomes 0 from nonzero
module dot_scoreboard #(
  parameter int N_DOTS  = 308,
  parameter int POINTS  = 10,
  parameter int SCORE_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N_DOTS-1:0]  show,
  input  logic               score_clr,
  output logic [SCORE_W-1:0] score,
  output logic [8:0]         dots_left,
  output logic               eat_pulse,
  output logic               pass_done,
  output logic               level_clear
);

  localparam int IDX_W = $clog2(N_DOTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOTS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [SCORE_W:0] PTS      = (SCORE_W + 1)'(POINTS);

  // PRIME: first pass after reset only loads the snapshot.
  localparam logic [0:0] PRIME = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]         state;
  logic [0:0]         state_next;
  logic [IDX_W-1:0]   idx;
  logic [N_DOTS-1:0]  snap;
  logic [8:0]         acc;

  logic               cur;
  logic               prev;
  logic               wrap;
  logic               primed;
  logic               eat;
  logic [8:0]         acc_next;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;

  // Sample the current bit and derive eat/count/wrap conditions.
  always_comb begin
    cur       = show[idx];
    prev      = snap[idx];
    wrap      = (idx == IDX_LAST);
    primed    = (state == RUN);
    eat       = primed && !prev && cur;
    acc_next  = acc + {8'd0, ~cur};
    // One extra bit catches the carry out so saturation is a single test.
    score_sum = {1'b0, score} + PTS;
    if (score_sum[SCORE_W]) begin
      score_sat = {SCORE_W{1'b1}};
    end else begin
      score_sat = score_sum[SCORE_W-1:0];
    end
  end

  // Priming state: leaves PRIME on the first wrap, only Reset returns.
  always_comb begin
    case (state)
      PRIME:   state_next = wrap ? RUN : PRIME;
      RUN:     state_next = RUN;
      default: state_next = PRIME;
    endcase
  end

  // State register, scan index, snapshot and zero-bit accumulator.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= PRIME;
      idx   <= '0;
      snap  <= '0;
      acc   <= 9'd0;
    end else begin
      state     <= state_next;
      snap[idx] <= cur;
      if (wrap) begin
        idx <= '0;
        acc <= 9'd0;
      end else begin
        idx <= idx + IDX_ONE;
        acc <= acc_next;
      end
    end
  end

  // Score and eat pulse; a clear in the same cycle as an eat wins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score     <= '0;
      eat_pulse <= 1'b0;
    end else begin
      eat_pulse <= eat;
      if (score_clr) begin
        score <= '0;
      end else if (eat) begin
        score <= score_sat;
      end else begin
        score <= score;
      end
    end
  end

  // Per-pass publication: dots_left, pass_done and level_clear together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      dots_left   <= 9'd0;
      pass_done   <= 1'b0;
      level_clear <= 1'b0;
    end else if (wrap) begin
      dots_left   <= acc_next;
      pass_done   <= 1'b1;
      level_clear <= primed && (acc_next == 9'd0) && (dots_left != 9'd0);
    end else begin
      dots_left   <= dots_left;
      pass_done   <= 1'b0;
      level_clear <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot_scoreboard.sv
module tb_dot_scoreboard;

  localparam int N = 308;

  logic          Clk;
  logic          Reset;
  logic [N-1:0]  show;
  logic          score_clr;

  logic [15:0]   score, score2;
  logic [8:0]    dots_left, dots_left2;
  logic          eat_pulse, eat_pulse2;
  logic          pass_done, pass_done2;
  logic          level_clear, level_clear2;

  int vectors     = 0;
  int miscompares = 0;
  int lc_count    = 0;
  bit started     = 1'b0;

  dot_scoreboard #(.N_DOTS(N), .POINTS(10), .SCORE_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .show(show), .score_clr(score_clr),
    .score(score), .dots_left(dots_left), .eat_pulse(eat_pulse),
    .pass_done(pass_done), .level_clear(level_clear)
  );

  dot_scoreboard #(.N_DOTS(N), .POINTS(60000), .SCORE_W(16)) dut_big (
    .Clk(Clk), .Reset(Reset), .show(show), .score_clr(score_clr),
    .score(score2), .dots_left(dots_left2), .eat_pulse(eat_pulse2),
    .pass_done(pass_done2), .level_clear(level_clear2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a scan position that walks the grid, the bits seen
  // last time round, and the score rules in plain integer arithmetic.
  int        m_pos;
  bit [N-1:0] m_seen;
  bit        m_primed;
  int        m_zeros;
  int        e_score, e_score2, e_dots;
  bit        e_eat, e_pass, e_lc;

  function automatic int sat_add(input int s, input int p);
    int r;
    r = s + p;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      started  = 1'b1;
      m_pos    = 0;
      m_seen   = '0;
      m_primed = 1'b0;
      m_zeros  = 0;
      e_score  = 0;
      e_score2 = 0;
      e_dots   = 0;
      e_eat    = 1'b0;
      e_pass   = 1'b0;
      e_lc     = 1'b0;
    end else if (started) begin
      bit b;
      b      = show[m_pos];
      e_eat  = m_primed && !m_seen[m_pos] && b;
      m_seen[m_pos] = b;
      if (!b) m_zeros++;
      if (score_clr) begin
        e_score  = 0;
        e_score2 = 0;
      end else if (e_eat) begin
        e_score  = sat_add(e_score, 10);
        e_score2 = sat_add(e_score2, 60000);
      end
      e_pass = 1'b0;
      e_lc   = 1'b0;
      if (m_pos == N - 1) begin
        e_lc     = m_primed && (m_zeros == 0) && (e_dots != 0);
        e_dots   = m_zeros;
        m_zeros  = 0;
        m_primed = 1'b1;
        e_pass   = 1'b1;
        m_pos    = 0;
      end else begin
        m_pos++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (started) begin
      check("score",       32'(score),       32'(e_score));
      check("score_big",   32'(score2),      32'(e_score2));
      check("dots_left",   32'(dots_left),   32'(e_dots));
      check("eat_pulse",   32'(eat_pulse),   32'(e_eat));
      check("pass_done",   32'(pass_done),   32'(e_pass));
      check("level_clear", 32'(level_clear), 32'(e_lc));
      check("eat_big",     32'(eat_pulse2),  32'(e_eat));
      if (level_clear === 1'b1) lc_count++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    int eats;
    int passes;
    int idxs[$];

    Reset     = 1'b1;
    score_clr = 1'b0;
    show      = '0;
    show[9:4]     = '1;
    show[307:206] = '1;
    step(3);
    check("rst_score",     32'(score),       32'd0);
    check("rst_dots",      32'(dots_left),   32'd0);
    check("rst_pass",      32'(pass_done),   32'd0);
    check("rst_eat",       32'(eat_pulse),   32'd0);
    Reset = 1'b0;

    // Priming pass: 200 zeros, pass_done exactly at cycle 308.
    eats = 0;
    for (int i = 0; i < 307; i++) begin
      step(1);
      if (eat_pulse === 1'b1) eats++;
      if (pass_done === 1'b1) eats = eats + 1000;
    end
    check("prime_quiet",   32'(eats),        32'd0);
    step(1);
    check("first_pass",    32'(pass_done),   32'd1);
    check("first_dots",    32'(dots_left),   32'd200);
    check("first_score",   32'(score),       32'd0);

    // One eaten dot at index 0, seen one cycle after idx 0 is sampled.
    show[0] = 1'b1;
    step(1);
    check("eat0_pulse",    32'(eat_pulse),   32'd1);
    check("eat0_score",    32'(score),       32'd10);
    check("eat0_big",      32'(score2),      32'd60000);
    step(307);
    check("pass2_done",    32'(pass_done),   32'd1);
    check("pass2_dots",    32'(dots_left),   32'd199);

    // Eat the remaining 199 dots one per pass.
    for (int i = 1; i <= 3; i++) idxs.push_back(i);
    for (int i = 10; i <= 205; i++) idxs.push_back(i);
    passes = 0;
    foreach (idxs[k]) begin
      show[idxs[k]] = 1'b1;
      step(308);
      passes++;
      if (passes == 1) check("sat_big", 32'(score2), 32'h0000FFFF);
    end
    check("clear_pass",    32'(pass_done),   32'd1);
    check("clear_dots",    32'(dots_left),   32'd0);
    check("clear_score",   32'(score),       32'd2000);
    check("clear_lc",      32'(level_clear), 32'd1);
    check("clear_big",     32'(score2),      32'h0000FFFF);
    step(616);
    check("lc_once",       32'(lc_count),    32'd1);

    // score_clr coinciding with an eat: clear wins, pulse still fires.
    show[0] = 1'b0;
    step(308);
    show[0]   = 1'b1;
    score_clr = 1'b1;
    step(1);
    score_clr = 1'b0;
    check("clr_score",     32'(score),       32'd0);
    check("clr_eat",       32'(eat_pulse),   32'd1);
    check("clr_big",       32'(score2),      32'd0);

    // Reset mid-pass at idx 150, change grid while in reset.
    step(149);
    Reset   = 1'b1;
    show[3] = 1'b0;
    show[7] = 1'b1;
    step(1);
    check("mid_rst_score", 32'(score),       32'd0);
    check("mid_rst_dots",  32'(dots_left),   32'd0);
    step(1);
    Reset = 1'b0;
    eats = 0;
    for (int i = 0; i < 307; i++) begin
      step(1);
      if (eat_pulse === 1'b1) eats++;
      if (pass_done === 1'b1) eats = eats + 1000;
    end
    check("reprime_quiet", 32'(eats),        32'd0);
    step(1);
    check("reprime_pass",  32'(pass_done),   32'd1);
    check("reprime_dots",  32'(dots_left),   32'd1);
    check("reprime_lc",    32'(level_clear), 32'd0);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
